dcache_repair_arbiter: RTL



---
 rtl/dcache_repair_arbiter_pkg.sv | 21 ++
 rtl/dcache_repair_arbiter_rr_arb2.sv | 37 +++
 rtl/dcache_repair_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dcache_repair_arbiter_pkg.sv
// Shared types and sizes for the L1 data-cache repair (refill) arbiter.
package dcache_repair_arbiter_pkg;

  localparam int unsigned DCACHE_ADDR_BITS   = 32;
  localparam int unsigned DCACHE_BLOCK_BITS  = 1024;
  localparam int unsigned DCACHE_OFFSET_BITS = 7;
  localparam int unsigned PERF_CNT_BITS      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } arb_state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rr_chan_e;

endpackage

// File: rtl/dcache_repair_arbiter_rr_arb2.sv
// Two-way round-robin grant between read and write repair requests; requests
// to the same block are coalesced into a single grant that leaves the pointer alone.
module rr_arb2
  import dcache_repair_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DCACHE_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  input  logic                 req_rd,
  input  logic                 req_wr,
  input  logic [ADDR_BITS-1:0] addr_rd,
  input  logic [ADDR_BITS-1:0] addr_wr,
  output logic                 gnt_rd_c,
  output logic                 gnt_wr_c
);

  rr_chan_e rr_ptr_q;
  logic     coalesce_c;

  // Addresses arrive block-aligned, so full equality means same block.
  always_comb begin
    coalesce_c = req_rd && req_wr && (addr_rd == addr_wr);
    gnt_rd_c   = req_rd && (!req_wr || coalesce_c || (rr_ptr_q == READ));
    gnt_wr_c   = req_wr && (!req_rd || coalesce_c || (rr_ptr_q == WRITE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= READ;
    end else if (arb_en && !coalesce_c && (gnt_rd_c || gnt_wr_c)) begin
      rr_ptr_q <= gnt_rd_c ? WRITE : READ;
    end
  end

endmodule

// File: rtl/dcache_repair_arbiter.sv
// Repair arbiter: grants read/write miss refills, fetches the block from memory
// and writes it back to the cache. Optional counters under DCACHE_ARB_PERF_EN.
module dcache_repair_arbiter
  import dcache_repair_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = DCACHE_ADDR_BITS,
  parameter int unsigned BLOCK_BITS  = DCACHE_BLOCK_BITS,
  parameter int unsigned OFFSET_BITS = DCACHE_OFFSET_BITS,
  parameter int unsigned MASK_BITS   = BLOCK_BITS / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_repair_request,
  input  logic                  write_repair_request,
  input  logic [ADDR_BITS-1:0]  missed_raddr,
  input  logic [ADDR_BITS-1:0]  missed_waddr,
  output logic                  read_repair_req_acq,
  output logic                  write_repair_req_acq,
  output logic                  repair_resolved,
  output logic [ADDR_BITS-1:0]  refill_addr,
  output logic [BLOCK_BITS-1:0] refill_data,
  output logic [MASK_BITS-1:0]  refill_wmask,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_BITS-1:0]  mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [BLOCK_BITS-1:0] mem_resp_data
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [PERF_CNT_BITS-1:0] perf_rd_repairs,
  output logic [PERF_CNT_BITS-1:0] perf_wr_repairs,
  output logic [PERF_CNT_BITS-1:0] perf_coalesced,
  output logic [PERF_CNT_BITS-1:0] perf_busy_cycles
`endif
);

  localparam logic [ADDR_BITS-1:0] BLK_MASK =
    ~ADDR_BITS'((64'd1 << OFFSET_BITS) - 64'd1);

  arb_state_e           state_q, state_n;
  logic [ADDR_BITS-1:0] addr_q, addr_n;
  logic [ADDR_BITS-1:0] raddr_blk_c, waddr_blk_c;
  logic                 idle_c, take_c, gnt_rd_c, gnt_wr_c;

  logic                  rd_acq_n, wr_acq_n, resolved_n, req_valid_n;
  logic [ADDR_BITS-1:0]  req_addr_n, refill_addr_n;
  logic [BLOCK_BITS-1:0] refill_data_n;

  assign raddr_blk_c = missed_raddr & BLK_MASK;
  assign waddr_blk_c = missed_waddr & BLK_MASK;
  assign idle_c      = (state_q == IDLE);
  assign take_c      = idle_c && (gnt_rd_c || gnt_wr_c);

  rr_arb2 #(.ADDR_BITS(ADDR_BITS)) u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (idle_c),
    .req_rd   (read_repair_request),
    .req_wr   (write_repair_request),
    .addr_rd  (raddr_blk_c),
    .addr_wr  (waddr_blk_c),
    .gnt_rd_c (gnt_rd_c),
    .gnt_wr_c (gnt_wr_c)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_n       = state_q;
    addr_n        = addr_q;
    rd_acq_n      = 1'b0;
    wr_acq_n      = 1'b0;
    resolved_n    = 1'b0;
    req_valid_n   = 1'b0;
    req_addr_n    = '0;
    refill_addr_n = '0;
    refill_data_n = '0;
    unique case (state_q)
      IDLE: begin
        if (take_c) begin
          state_n     = REQ;
          addr_n      = gnt_rd_c ? raddr_blk_c : waddr_blk_c;
          rd_acq_n    = gnt_rd_c;
          wr_acq_n    = gnt_wr_c;
          req_valid_n = 1'b1;
          req_addr_n  = addr_n;
        end
      end
      REQ: begin
        if (mem_req_valid && mem_req_ready) begin
          state_n = WAIT;
        end else begin
          req_valid_n = 1'b1;
          req_addr_n  = addr_q;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_n       = FILL;
          resolved_n    = 1'b1;
          refill_addr_n = addr_q;
          refill_data_n = mem_resp_data;
        end
      end
      FILL: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= IDLE;
      addr_q               <= '0;
      read_repair_req_acq  <= 1'b0;
      write_repair_req_acq <= 1'b0;
      repair_resolved      <= 1'b0;
      refill_addr          <= '0;
      refill_data          <= '0;
      refill_wmask         <= '0;
      mem_req_valid        <= 1'b0;
      mem_req_addr         <= '0;
    end else begin
      state_q              <= state_n;
      addr_q               <= addr_n;
      read_repair_req_acq  <= rd_acq_n;
      write_repair_req_acq <= wr_acq_n;
      repair_resolved      <= resolved_n;
      refill_addr          <= refill_addr_n;
      refill_data          <= refill_data_n;
      refill_wmask         <= resolved_n ? '1 : '0;
      mem_req_valid        <= req_valid_n;
      mem_req_addr         <= req_addr_n;
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  // Free-running event counters; a coalesced grant counts on both channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_repairs  <= '0;
      perf_wr_repairs  <= '0;
      perf_coalesced   <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (take_c && gnt_rd_c) perf_rd_repairs <= perf_rd_repairs + PERF_CNT_BITS'(1);
      if (take_c && gnt_wr_c) perf_wr_repairs <= perf_wr_repairs + PERF_CNT_BITS'(1);
      if (take_c && gnt_rd_c && gnt_wr_c) perf_coalesced <= perf_coalesced + PERF_CNT_BITS'(1);
      if (!idle_c) perf_busy_cycles <= perf_busy_cycles + PERF_CNT_BITS'(1);
    end
  end
`endif

endmodule
